// File: rtl/instr_fetch_unit.sv
// Fetch stage between the UART-loaded instruction ROM and decode.
// Walks a PC across the loaded program and hands each word to decode via valid/ready.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 8'h00
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load_done,
    input  logic [ADDR_WIDTH-1:0]  i_max_addr,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [ADDR_WIDTH-1:0]  o_addr_read,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_addr,
    output logic                   o_halted,
    output logic                   o_fault
);

    localparam logic [2:0] ST_WAIT_LOAD = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_HALTED    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  addr_read_q, addr_read_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   fault_q, fault_d;
    logic                   ld_meta_q, ld_meta_d;
    logic                   ld_s_q, ld_s_d;
    logic                   redirect_ok_s;

    // Synchroniser inputs and redirect range check.
    always_comb begin
        ld_meta_d     = i_load_done;
        ld_s_d        = ld_meta_q;
        redirect_ok_s = (i_redirect_addr <= i_max_addr);
    end

    // Next-state logic: reload beats redirect, redirect beats normal sequencing.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;

        if (!ld_s_q) begin
            state_d  = ST_WAIT_LOAD;
            pc_d     = START_ADDR;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            fault_d  = 1'b0;
        end else if (i_redirect && (state_q != ST_WAIT_LOAD)) begin
            // A HOLD handshake in this cycle is simply absorbed: the redirect owns the PC.
            valid_d = 1'b0;
            if (redirect_ok_s) begin
                pc_d     = i_redirect_addr;
                halted_d = 1'b0;
                state_d  = ST_ISSUE;
            end else begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
                state_d  = ST_HALTED;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOAD: begin
                    valid_d = 1'b0;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    instr_d  = i_instr;
                    out_pc_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        if (pc_q == i_max_addr) begin
                            halted_d = 1'b1;
                            state_d  = ST_HALTED;
                        end else begin
                            pc_d    = pc_q + PC_ONE;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HALTED: begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_LOAD;
                end
            endcase
        end

        // The ROM address tracks the PC so it is already presented during ISSUE.
        addr_read_d = pc_d;
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_WAIT_LOAD;
            pc_q        <= START_ADDR;
            addr_read_q <= START_ADDR;
            instr_q     <= {INSTR_WIDTH{1'b0}};
            out_pc_q    <= {ADDR_WIDTH{1'b0}};
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            ld_meta_q   <= 1'b0;
            ld_s_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_read_q <= addr_read_d;
            instr_q     <= instr_d;
            out_pc_q    <= out_pc_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            ld_meta_q   <= ld_meta_d;
            ld_s_q      <= ld_s_d;
        end
    end

    assign o_addr_read = addr_read_q;
    assign o_instr     = instr_q;
    assign o_pc        = out_pc_q;
    assign o_valid     = valid_q;
    assign o_halted    = halted_q;
    assign o_fault     = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the UART-loaded instruction ROM.
- Waits for the ROM load-complete flag, then walks a program counter from START_ADDR to the ROM's reported max address.
- Drives the ROM read address and captures each 16-bit instruction.
- Presents each instruction to decode with a valid/ready handshake; accepts branch redirects from execute.

Parameters:
ADDR_WIDTH, 8, width of PC and ROM read address
INSTR_WIDTH, 16, instruction word width
START_ADDR, 8'h00, PC value after reset and after each new program load

Ports:
i_clk  input  1  CPU clock (50 MHz); same clock as the ROM read port
i_rst  input  1  asynchronous, active-high reset
i_load_done  input  1  ROM load-complete flag (transmit done); asynchronous to i_clk, synchronised internally
i_max_addr  input  ADDR_WIDTH  address of the last loaded instruction, inclusive
i_instr  input  INSTR_WIDTH  ROM read data, valid one cycle after address
o_addr_read  output  ADDR_WIDTH  ROM read address
o_instr  output  INSTR_WIDTH  instruction to decode
o_pc  output  ADDR_WIDTH  address of o_instr
o_valid  output  1  o_instr/o_pc valid
i_ready  input  1  decode accepts when o_valid & i_ready
i_redirect  input  1  one-cycle branch/jump request
i_redirect_addr  input  ADDR_WIDTH  redirect target
o_halted  output  1  program end reached
o_fault  output  1  sticky: redirect target > i_max_addr

Behaviour:
- Reset (async, i_rst=1):
  - FSM=WAIT_LOAD; pc=START_ADDR; o_addr_read=START_ADDR; o_instr=0; o_pc=0.
  - o_valid=0; o_halted=0; o_fault=0; synchroniser flops=0.
- i_load_done passes a 2-flop synchroniser (ld_s). All FSM decisions use ld_s, so there are 2 cycles of latency.
- ROM read latency is exactly 1 cycle: address registered in cycle N, i_instr valid in N+1.
- FSM:
  - WAIT_LOAD: o_valid=0; o_addr_read=START_ADDR. ld_s=1 -> ISSUE.
  - ISSUE: o_addr_read=pc -> CAPTURE.
  - CAPTURE: o_instr<=i_instr; o_pc<=pc; o_valid<=1 -> HOLD.
  - HOLD: o_valid=1; o_instr and o_pc stable until accepted.
    - i_ready=1 and pc==i_max_addr: o_valid<=0 -> HALTED.
    - i_ready=1 otherwise: pc<=pc+1; o_valid<=0 -> ISSUE.
    - i_ready=0: stay in HOLD.
  - HALTED: o_halted=1; o_valid=0; no further ROM reads change state.
- Throughput: one instruction per 3 cycles with i_ready held high. First o_valid appears 2 cycles after entering ISSUE.
- Redirect, accepted in ISSUE, CAPTURE, HOLD and HALTED; ignored in WAIT_LOAD:
  - Target <= i_max_addr: pc<=target; o_valid<=0; o_halted<=0 -> ISSUE. Any in-flight read is discarded.
  - Target > i_max_addr: o_valid<=0; o_fault<=1 -> HALTED.
  - Redirect in the same cycle as a HOLD handshake: the held instruction counts as accepted; redirect wins over pc+1 and over the halt.
- Reload: ld_s falling in any state -> WAIT_LOAD with o_valid=0, o_halted=0, o_fault=0, pc=START_ADDR. Highest priority after reset.
- PC arithmetic is ADDR_WIDTH-bit unsigned. PC never wraps, because a fetch at pc==i_max_addr halts (covers max=8'hFF).
- i_max_addr is sampled live; it is required to be stable while ld_s=1.
- Reset mid-operation: immediate async return to the reset values above, with no partial handshake.

Test Plan:
- Load 4 words at addr 0..3, i_max_addr=3, i_ready=1 -> o_valid pulses with o_pc=0,1,2,3 and matching o_instr, every 3 cycles; then o_halted=1, o_valid stays 0.
- i_load_done rises -> o_addr_read leaves START_ADDR no earlier than 3 cycles later (2-cycle sync + ISSUE); o_valid first high 2 cycles after ISSUE.
- Backpressure: i_ready=0 for 5 cycles in HOLD at pc=1 -> o_instr and o_pc=1 held constant; no ROM address change; accepted on i_ready=1; next o_pc=2.
- Redirect to 0 in the same cycle as handshake at pc=2 -> next o_pc=0, not 3. Redirect to 8'h10 with max=3 -> o_fault=1, o_halted=1.
- i_max_addr=8'hFF with 256 words -> last o_pc=8'hFF, then halted, no wrap to 0.
- i_load_done drops then rises mid-run at pc=5 -> o_valid=0 and pc=0; o_halted and o_fault cleared; fetch restarts at 0. i_rst pulse in CAPTURE -> all outputs at reset values in the same cycle.
